// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state, transaction owner
// and the byte-enable width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int BE_W = 4;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Response watchdog: counts busy cycles and flags expiry once TIMEOUT cycles have
// been spent in the busy window; the count restarts whenever busy drops.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          busy,
    output logic          expired,
    output logic [CW-1:0] count
);

    assign expired = busy && (count == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!busy) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port I/D memory between fetch and load/store, one transaction
// at a time. Define MEM_ARB_TIMEOUT_EN to add the response watchdog and sticky mem_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FAIR_LIMIT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               if_req,
    input  logic [XLEN-1:0]                    if_addr,
    output logic [XLEN-1:0]                    if_rdata,
    output logic                               if_valid,
    input  logic                               d_req,
    input  logic                               d_we,
    input  logic [BE_W-1:0]                    d_be,
    input  logic [XLEN-1:0]                    d_addr,
    input  logic [XLEN-1:0]                    d_wdata,
    output logic [XLEN-1:0]                    d_rdata,
    output logic                               d_valid,
    output logic                               stall_if,
    output logic                               stall_mem,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [BE_W-1:0]                    mem_be,
    output logic [XLEN-1:0]                    mem_addr,
    output logic [XLEN-1:0]                    mem_wdata,
    input  logic                               mem_gnt,
    input  logic                               mem_rvalid,
    input  logic [XLEN-1:0]                    mem_rdata,
    output logic                               mem_err,
    output arb_state_t                         dbg_state,
    output logic [$clog2(FAIR_LIMIT+1)-1:0]    dbg_cnt,
    output logic [$clog2(TIMEOUT+1)-1:0]       dbg_wd_cnt
);

    localparam int CNT_W = $clog2(FAIR_LIMIT + 1);

    // Handshake: requests are levels held until their one-cycle *_valid; mem_req
    // is held with stable fields until mem_gnt; mem_rvalid counts only in WAIT_RESP.
    arb_state_t       state, state_nxt;
    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             pick_if, grant, done, wd_expired;
    logic [XLEN-1:0]  resp_data;

    // Fetch wins only when data is idle or data has used up its fairness budget.
    assign pick_if = if_req && (!d_req || (cnt == CNT_W'(FAIR_LIMIT)));

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant     = 1'b1;
                    state_nxt = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (wd_expired) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (mem_gnt) begin
                    state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_rvalid || wd_expired) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_IF;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (state_nxt == WAIT_GNT);
            if (grant) begin
                if (pick_if) begin
                    owner     <= OWN_IF;
                    cnt       <= '0;
                    mem_we    <= 1'b0;
                    mem_be    <= '1;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                end else begin
                    owner     <= OWN_D;
                    mem_we    <= d_we;
                    mem_be    <= d_be;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    if (!if_req) begin
                        cnt <= '0;
                    end else if (cnt != CNT_W'(FAIR_LIMIT)) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // A watchdog completion carries zero data; a real response in the same cycle wins.
    assign resp_data = (state == WAIT_RESP && mem_rvalid) ? mem_rdata : '0;
    assign if_valid  = done && (owner == OWN_IF);
    assign d_valid   = done && (owner == OWN_D);
    assign if_rdata  = if_valid ? resp_data : '0;
    assign d_rdata   = d_valid ? resp_data : '0;
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = d_req && !d_valid;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_done;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .busy    (state != IDLE),
        .expired (wd_expired),
        .count   (dbg_wd_cnt)
    );

    assign timeout_done = wd_expired && !(state == WAIT_RESP && mem_rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err <= 1'b0;
        end else if (timeout_done) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign dbg_wd_cnt = '0;
    assign mem_err    = 1'b0;
`endif

endmodule
